piso_tx: RTL and testbench

- Parallel-in, serial-out transmitter: accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per CLK cycle.
- Emits per-bit valid, a last-bit flag, and an end-of-frame pulse.
- Counterpart to the team's serial-in/parallel-out capture register: it drives the D line that such a register samples.
- Sits between a parallel word source and any serial sink clocked by the same CLK.

---
 rtl/piso_tx_pkg.sv | 12 +
 rtl/piso_tx_bit_cnt.sv | 30 +++
 rtl/piso_tx.sv | 89 ++++++++
 tb/tb_piso_tx.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/piso_tx_pkg.sv
// Shared definitions for the serial transmitter and its capture-side counterpart:
// FSM state encodings and the default word width.
package piso_tx_pkg;

  localparam int PISO_WIDTH_DEF = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } piso_state_e;

endpackage

// File: rtl/piso_tx_bit_cnt.sv
// Bit-position counter for one frame; saturates at WIDTH-1 rather than wrapping.
// Terminal-count flag is combinational from the count register.
module piso_bit_cnt #(
  parameter int WIDTH = 4
) (
  input  logic CLK,
  input  logic CLR,
  input  logic clear,
  input  logic enable,
  output logic o_tc
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(WIDTH - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && (r_cnt != TC_VAL)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: one WIDTH-bit word per frame, one bit per CLK,
// first bit the cycle after accept, back-to-back frames with no gap.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH     = PISO_WIDTH_DEF,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD,
  output logic             READY,
  output logic             DOUT,
  output logic             DVALID,
  output logic             LAST,
  output logic             DONE
);

  piso_state_e      r_state;
  piso_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic             r_done;
  logic             w_tc;
  logic             w_last;
  logic             w_accept;
  logic             w_shifting;

  assign w_shifting = (r_state == ST_SHIFT);
  assign w_last     = w_shifting && w_tc;
  // READY looks only at state/counter so the source may gate LOAD on it freely.
  assign READY      = !w_shifting || w_tc;
  assign w_accept   = LOAD && READY;

  piso_bit_cnt #(
    .WIDTH (WIDTH)
  ) u_bit_cnt (
    .CLK    (CLK),
    .CLR    (CLR),
    .clear  (w_accept || w_last),
    .enable (w_shifting),
    .o_tc   (w_tc)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last && !w_accept) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_shreg <= '0;
    end else if (w_accept) begin
      r_shreg <= DIN;
    end else if (w_shifting) begin
      if (LSB_FIRST) begin
        r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
      end else begin
        r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
    end
  end

  assign DVALID = w_shifting;
  assign DOUT   = w_shifting && (LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1]);
  assign LAST   = w_last;
  assign DONE   = r_done;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: WIDTH=4 MSB-first instance plus WIDTH=8 LSB-first instance
// with a serial-in register model on its output.
module tb_piso_tx;

  logic       CLK;
  logic       CLR;
  logic [3:0] din4;
  logic       load4;
  logic       ready4, dout4, dvalid4, last4, done4;
  logic [7:0] din8;
  logic       load8;
  logic       ready8, dout8, dvalid8, last8, done8;

  int checks = 0;
  int errors = 0;

  piso_tx #(.WIDTH(4), .LSB_FIRST(1'b0)) dut4 (
    .CLK(CLK), .CLR(CLR), .DIN(din4), .LOAD(load4), .READY(ready4),
    .DOUT(dout4), .DVALID(dvalid4), .LAST(last4), .DONE(done4)
  );

  piso_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut8 (
    .CLK(CLK), .CLR(CLR), .DIN(din8), .LOAD(load8), .READY(ready8),
    .DOUT(dout8), .DVALID(dvalid8), .LAST(last8), .DONE(done8)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected READY, DOUT, DVALID, LAST, DONE of the WIDTH=4 instance.
  task automatic chk4(input string tag, input logic rdy, input logic d, input logic v,
                      input logic l, input logic dn);
    chk1({tag, ".ready"},  ready4,  rdy);
    chk1({tag, ".dout"},   dout4,   d);
    chk1({tag, ".dvalid"}, dvalid4, v);
    chk1({tag, ".last"},   last4,   l);
    chk1({tag, ".done"},   done4,   dn);
  endtask

  logic [7:0] rx8;
  logic [7:0] exp_bits8;

  initial begin
    CLR   = 1'b0;
    load4 = 1'b1;
    din4  = 4'hF;
    load8 = 1'b0;
    din8  = 8'h00;
    rx8   = 8'h00;

    // Reset held with LOAD asserted: nothing may start.
    #30;
    chk4("reset", 1, 0, 0, 0, 0);
    load4 = 1'b0;
    CLR   = 1'b1;
    tick();
    chk4("post_reset", 1, 0, 0, 0, 0);

    // Single frame 1011, MSB first.
    din4 = 4'b1011; load4 = 1'b1;
    tick(); load4 = 1'b0; din4 = 4'h0;
    chk4("single.b0", 0, 1, 1, 0, 0);
    tick(); chk4("single.b1", 0, 0, 1, 0, 0);
    tick(); chk4("single.b2", 0, 1, 1, 0, 0);
    tick(); chk4("single.b3", 1, 1, 1, 1, 0);
    tick(); chk4("single.done", 1, 0, 0, 0, 1);
    tick(); chk4("single.idle", 1, 0, 0, 0, 0);

    // Back-to-back: 1011 then 0110 loaded during the LAST cycle.
    din4 = 4'b1011; load4 = 1'b1;
    tick(); load4 = 1'b0;
    chk4("b2b.f1b0", 0, 1, 1, 0, 0);
    tick(); chk4("b2b.f1b1", 0, 0, 1, 0, 0);
    tick(); chk4("b2b.f1b2", 0, 1, 1, 0, 0);
    tick(); chk4("b2b.f1b3", 1, 1, 1, 1, 0);
    din4 = 4'b0110; load4 = 1'b1;
    tick(); load4 = 1'b0; din4 = 4'h0;
    chk4("b2b.f2b0", 0, 0, 1, 0, 1);
    tick(); chk4("b2b.f2b1", 0, 1, 1, 0, 0);
    tick(); chk4("b2b.f2b2", 0, 1, 1, 0, 0);
    tick(); chk4("b2b.f2b3", 1, 0, 1, 1, 0);
    tick(); chk4("b2b.done", 1, 0, 0, 0, 1);
    tick(); chk4("b2b.idle", 1, 0, 0, 0, 0);

    // Busy load: LOAD with 0000 during bit 1 of 1111 must be ignored.
    din4 = 4'b1111; load4 = 1'b1;
    tick(); load4 = 1'b0;
    chk4("busy.b0", 0, 1, 1, 0, 0);
    tick(); chk4("busy.b1", 0, 1, 1, 0, 0);
    din4 = 4'b0000; load4 = 1'b1;
    tick(); load4 = 1'b0;
    chk4("busy.b2", 0, 1, 1, 0, 0);
    tick(); chk4("busy.b3", 1, 1, 1, 1, 0);
    tick(); chk4("busy.done", 1, 0, 0, 0, 1);
    tick(); chk4("busy.idle", 1, 0, 0, 0, 0);

    // Mid-frame asynchronous reset during bit 2 of 1010.
    din4 = 4'b1010; load4 = 1'b1;
    tick(); load4 = 1'b0;
    chk4("abort.b0", 0, 1, 1, 0, 0);
    tick(); chk4("abort.b1", 0, 0, 1, 0, 0);
    tick(); chk4("abort.b2", 0, 1, 1, 0, 0);
    CLR = 1'b0;
    #1;
    chk4("abort.clr", 1, 0, 0, 0, 0);
    #1;
    CLR = 1'b1;
    tick(); chk4("abort.after1", 1, 0, 0, 0, 0);
    tick(); chk4("abort.after2", 1, 0, 0, 0, 0);

    // Clean frame 0101 after the abort.
    din4 = 4'b0101; load4 = 1'b1;
    tick(); load4 = 1'b0;
    chk4("recover.b0", 0, 0, 1, 0, 0);
    tick(); chk4("recover.b1", 0, 1, 1, 0, 0);
    tick(); chk4("recover.b2", 0, 0, 1, 0, 0);
    tick(); chk4("recover.b3", 1, 1, 1, 1, 0);
    tick(); chk4("recover.done", 1, 0, 0, 0, 1);

    // WIDTH=8, LSB first: A5 -> 1,0,1,0,0,1,0,1 (index i = bit i on the wire).
    exp_bits8 = 8'b1010_0101;
    chk1("w8.ready_idle", ready8, 1'b1);
    din8 = 8'hA5; load8 = 1'b1;
    tick(); load8 = 1'b0; din8 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk1($sformatf("w8.b%0d.dvalid", i), dvalid8, 1'b1);
      chk1($sformatf("w8.b%0d.dout", i), dout8, exp_bits8[i]);
      chk1($sformatf("w8.b%0d.last", i), last8, (i == 7) ? 1'b1 : 1'b0);
      chk1($sformatf("w8.b%0d.done", i), done8, 1'b0);
      if (dvalid8) rx8 = {dout8, rx8[7:1]};
      tick();
    end
    chk1("w8.done", done8, 1'b1);
    chk1("w8.dvalid_end", dvalid8, 1'b0);
    chk8("w8.loopback", rx8, 8'hA5);
    tick();
    chk1("w8.done_clear", done8, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
